jstk_poll_scheduler: RTL and testbench

- Shares one SPI mode-0 master engine between the two joystick modules (left = device 1, right = device 2) and polls them alternately.
- Per transaction: drives SS for one device, exchanges 5 bytes, decodes X, Y and buttons, then publishes them in per-device holding registers with an update pulse.
- Feeds the direction-threshold and sender logic in the slave top level, replacing the per-rocker free-running SPI drivers.

---
 rtl/jstk_poll_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_jstk_poll_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jstk_poll_scheduler.sv
// Alternately polls two joystick modules over one shared SPI mode-0 master,
// decoding X/Y/buttons into per-device holding registers with update pulses.
module jstk_poll_scheduler #(
    parameter int SCLK_DIV = 4,
    parameter int SS_SETUP = 16,
    parameter int BYTE_GAP = 16,
    parameter int POLL_GAP = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] led_1,
    input  logic [1:0] led_2,
    input  logic       miso_1,
    input  logic       miso_2,
    output logic       ss_1,
    output logic       ss_2,
    output logic       sclk,
    output logic       mosi,
    output logic [9:0] x_1,
    output logic [9:0] y_1,
    output logic [2:0] btn_1,
    output logic [9:0] x_2,
    output logic [9:0] y_2,
    output logic [2:0] btn_2,
    output logic       upd_1,
    output logic       upd_2,
    output logic       busy
);

    localparam int MAX_A = (POLL_GAP > SS_SETUP) ? POLL_GAP : SS_SETUP;
    localparam int MAX_B = (MAX_A > BYTE_GAP) ? MAX_A : BYTE_GAP;
    localparam int CNT_W = (MAX_B > 1) ? $clog2(MAX_B) : 1;
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    // Reload values: a state with a zero-length parameter still lasts one cycle.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SS_SETUP > 0) ? SS_SETUP - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((BYTE_GAP > 0) ? BYTE_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] POLL_LD  = CNT_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [2:0]       byte_q, byte_d;
    logic             sclk_q, sclk_d;
    logic             ptr_q, ptr_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [9:0]       x_sh_q, x_sh_d;
    logic [9:0]       y_sh_q, y_sh_d;
    logic [9:0]       x_q [0:1];
    logic [9:0]       x_d [0:1];
    logic [9:0]       y_q [0:1];
    logic [9:0]       y_d [0:1];
    logic [2:0]       btn_q [0:1];
    logic [2:0]       btn_d [0:1];

    logic miso_sel;
    logic ss_active;

    assign miso_sel  = ptr_q ? miso_2 : miso_1;
    assign ss_active = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_GAP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sclk_d  = sclk_q;
        ptr_d   = ptr_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        x_sh_d  = x_sh_q;
        y_sh_d  = y_sh_q;
        x_d     = x_q;
        y_d     = y_q;
        btn_d   = btn_q;

        case (state_q)
            ST_IDLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (enable) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LD;
                    byte_d  = 3'd0;
                    tx_d    = {6'b100000, ptr_q ? led_2 : led_1};
                end
            end
            ST_SETUP, ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_SHIFT;
                    div_d   = '0;
                    bit_d   = 3'd0;
                    sclk_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 1'b1;
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Rising SCLK: sample the selected device.
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], miso_sel};
                    end else begin
                        // Falling SCLK: advance MOSI, possibly close the byte.
                        sclk_d = 1'b0;
                        tx_d   = {tx_q[6:0], 1'b0};
                        if (bit_q != 3'd7) begin
                            bit_d = bit_q + 3'd1;
                        end else begin
                            bit_d = 3'd0;
                            case (byte_q)
                                3'd0:    x_sh_d[7:0] = rx_q;
                                3'd1:    x_sh_d[9:8] = rx_q[1:0];
                                3'd2:    y_sh_d[7:0] = rx_q;
                                3'd3:    y_sh_d[9:8] = rx_q[1:0];
                                default: ;
                            endcase
                            if (byte_q == 3'd4) begin
                                // Publish on DONE entry so data is valid with the pulse.
                                state_d       = ST_DONE;
                                x_d[ptr_q]    = x_sh_q;
                                y_d[ptr_q]    = y_sh_q;
                                btn_d[ptr_q]  = rx_q[2:0];
                            end else begin
                                state_d = ST_GAP;
                                cnt_d   = GAP_LD;
                                byte_d  = byte_q + 3'd1;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = POLL_LD;
                ptr_d   = ~ptr_q;
                tx_d    = 8'h00;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 3'd0;
            sclk_q  <= 1'b0;
            ptr_q   <= 1'b0;
            tx_q    <= 8'h00;
            rx_q    <= 8'h00;
            x_sh_q  <= '0;
            y_sh_q  <= '0;
            x_q     <= '{default: '0};
            y_q     <= '{default: '0};
            btn_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sclk_q  <= sclk_d;
            ptr_q   <= ptr_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            x_sh_q  <= x_sh_d;
            y_sh_q  <= y_sh_d;
            x_q     <= x_d;
            y_q     <= y_d;
            btn_q   <= btn_d;
        end
    end

    assign ss_1  = ~(ss_active & ~ptr_q);
    assign ss_2  = ~(ss_active & ptr_q);
    assign sclk  = sclk_q;
    assign mosi  = tx_q[7];
    assign busy  = (state_q != ST_IDLE);
    assign upd_1 = (state_q == ST_DONE) & ~ptr_q;
    assign upd_2 = (state_q == ST_DONE) & ptr_q;
    assign x_1   = x_q[0];
    assign y_1   = y_q[0];
    assign btn_1 = btn_q[0];
    assign x_2   = x_q[1];
    assign y_2   = y_q[1];
    assign btn_2 = btn_q[1];

endmodule

// File: tb/tb_jstk_poll_scheduler.sv
// Directed bench for jstk_poll_scheduler: two behavioural SPI joystick
// models on a shared bus, with timing, decode, alternation and reset checks.
`timescale 1ns/1ps
module tb_jstk_poll_scheduler;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] led_1, led_2;
    logic       miso_1, miso_2;
    logic       ss_1, ss_2, sclk, mosi;
    logic [9:0] x_1, y_1, x_2, y_2;
    logic [2:0] btn_1, btn_2;
    logic       upd_1, upd_2, busy;

    int errors = 0;
    int checks = 0;

    jstk_poll_scheduler dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .led_1  (led_1),
        .led_2  (led_2),
        .miso_1 (miso_1),
        .miso_2 (miso_2),
        .ss_1   (ss_1),
        .ss_2   (ss_2),
        .sclk   (sclk),
        .mosi   (mosi),
        .x_1    (x_1),
        .y_1    (y_1),
        .btn_1  (btn_1),
        .x_2    (x_2),
        .y_2    (y_2),
        .btn_2  (btn_2),
        .upd_1  (upd_1),
        .upd_2  (upd_2),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Device response streams, 5 bytes MSB first.
    logic [39:0] resp1, resp2;

    // Bus monitor: SCLK rise count, MOSI capture, edge timestamps.
    int          rise_cnt = 0;
    logic [39:0] mosi_cap = '0;
    int          ss_fall_cyc = 0, first_rise = 0, prev_rise = 0, last_rise = 0;
    always @(negedge ss_1 or negedge ss_2 or posedge sclk) begin
        if (sclk) begin
            rise_cnt++;
            mosi_cap  = {mosi_cap[38:0], mosi};
            prev_rise = last_rise;
            last_rise = cyc;
            if (rise_cnt == 1) first_rise = cyc;
        end else begin
            rise_cnt    = 0;
            mosi_cap    = '0;
            ss_fall_cyc = cyc;
        end
    end

    // Mode-0 slaves: bit k is presented from the falling edge before rise k+1.
    int bit_idx;
    always_comb bit_idx = rise_cnt - int'(sclk);
    always_comb begin
        miso_1 = 1'b0;
        miso_2 = 1'b0;
        if (bit_idx >= 0 && bit_idx < 40) begin
            if (!ss_1) miso_1 = resp1[39 - bit_idx];
            if (!ss_2) miso_2 = resp2[39 - bit_idx];
        end
    end

    int overlap_cnt = 0;
    int upd1_cnt = 0, upd2_cnt = 0;
    always @(negedge clk) begin
        if (!ss_1 && !ss_2) overlap_cnt++;
        if (upd_1) upd1_cnt++;
        if (upd_2) upd2_cnt++;
    end

    int t_upd1 = 0, t_upd2 = 0;

    // Bounded wait at negedges: 1=upd_1, 2=upd_2, 3=ss_1 low, 4=ss_2 low.
    task automatic wait_sig(input int which, input int budget, output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < budget) begin
            @(negedge clk);
            waited++;
            case (which)
                1:       seen = upd_1;
                2:       seen = upd_2;
                3:       seen = !ss_1;
                default: seen = !ss_2;
            endcase
        end
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        enable = 1'b1;
        led_1  = 2'b01;
        led_2  = 2'b10;
        resp1  = {8'h34, 8'h02, 8'hCD, 8'h01, 8'h05};
        resp2  = {8'hFF, 8'hFE, 8'h00, 8'h03, 8'hFF};
        repeat (4) @(negedge clk);
        checks++;
        if ({ss_1, ss_2, sclk, mosi, busy, upd_1, upd_2} !== 7'b1100000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 1100000", {ss_1, ss_2, sclk, mosi, busy, upd_1, upd_2});
        end
        checks++;
        if ({x_1, y_1, btn_1, x_2, y_2, btn_2} !== 46'd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {x_1, y_1, btn_1, x_2, y_2, btn_2});
        end
        $display("txn reset: controls and data checked");
    endtask

    task automatic test_first_txn();
        bit seen;
        int w;
        int low1, low2, n;
        rst = 1'b1;
        wait_sig(3, 5, seen, w);
        checks++;
        if (!seen || w != 1) begin
            errors++;
            $display("FAIL first_start: seen=%0d after %0d cycles want seen=1 after 1", seen, w);
        end
        low1 = 1; low2 = 0; n = 0; seen = 1'b0;
        while (!seen && n < 1000) begin
            @(negedge clk);
            n++;
            if (!ss_1) low1++;
            if (!ss_2) low2++;
            seen = upd_1;
        end
        t_upd1 = cyc;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL first_upd1: no upd_1 within 1000 cycles");
        end
        checks++;
        if (low1 != 400 || low2 != 0) begin
            errors++;
            $display("FAIL first_ss_len: ss_1 low %0d ss_2 low %0d want 400 and 0", low1, low2);
        end
        checks++;
        if (x_1 !== 10'h234 || y_1 !== 10'h1CD || btn_1 !== 3'b101) begin
            errors++;
            $display("FAIL first_decode: x=%h y=%h btn=%b want 234 1cd 101", x_1, y_1, btn_1);
        end
        checks++;
        if ({x_2, y_2, btn_2} !== 23'd0) begin
            errors++;
            $display("FAIL first_dev2_hold: got %h want 0", {x_2, y_2, btn_2});
        end
        checks++;
        if (mosi_cap !== {8'h81, 32'h0} || rise_cnt != 40) begin
            errors++;
            $display("FAIL first_mosi: got %h rises=%0d want 8100000000 rises=40", mosi_cap, rise_cnt);
        end
        checks++;
        if (first_rise - ss_fall_cyc != 20 || last_rise - prev_rise != 8) begin
            errors++;
            $display("FAIL first_timing: setup=%0d period=%0d want 20 and 8",
                     first_rise - ss_fall_cyc, last_rise - prev_rise);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL first_busy_done: got %b want 1", busy);
        end
        @(negedge clk);
        checks++;
        if (upd_1 !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL first_pulse_end: upd_1=%b busy=%b want 0 0", upd_1, busy);
        end
        $display("txn dev1: x=%h y=%h btn=%b ss_low=%0d mosi=%h", x_1, y_1, btn_1, low1, mosi_cap);
    endtask

    task automatic test_alternate();
        bit seen;
        int w;
        wait_sig(2, 1500, seen, w);
        t_upd2 = cyc;
        checks++;
        if (!seen || t_upd2 - t_upd1 != 1401) begin
            errors++;
            $display("FAIL alt_upd2: seen=%0d delta=%0d want 1 and 1401", seen, t_upd2 - t_upd1);
        end
        checks++;
        if (x_2 !== 10'h2FF || y_2 !== 10'h300 || btn_2 !== 3'b111) begin
            errors++;
            $display("FAIL alt_decode2: x=%h y=%h btn=%b want 2ff 300 111", x_2, y_2, btn_2);
        end
        checks++;
        if (mosi_cap !== {8'h82, 32'h0}) begin
            errors++;
            $display("FAIL alt_mosi2: got %h want 8200000000", mosi_cap);
        end
        checks++;
        if (x_1 !== 10'h234 || y_1 !== 10'h1CD || btn_1 !== 3'b101) begin
            errors++;
            $display("FAIL alt_dev1_hold: x=%h y=%h btn=%b want 234 1cd 101", x_1, y_1, btn_1);
        end
        $display("txn dev2: x=%h y=%h btn=%b delta=%0d", x_2, y_2, btn_2, t_upd2 - t_upd1);
        wait_sig(1, 1500, seen, w);
        t_upd1 = cyc;
        checks++;
        if (!seen || t_upd1 - t_upd2 != 1401) begin
            errors++;
            $display("FAIL alt_upd1: seen=%0d delta=%0d want 1 and 1401", seen, t_upd1 - t_upd2);
        end
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL alt_overlap: both selects low for %0d cycles want 0", overlap_cnt);
        end
        $display("txn dev1: x=%h delta=%0d overlap=%0d", x_1, t_upd1 - t_upd2, overlap_cnt);
    endtask

    task automatic test_enable_drop();
        bit seen;
        int w;
        int viol;
        resp2 = {8'h12, 8'h03, 8'h56, 8'h00, 8'h02};
        wait_sig(4, 1500, seen, w);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL en_start2: ss_2 never fell within 1500 cycles");
        end
        repeat (180) @(negedge clk);
        enable = 1'b0;
        wait_sig(2, 400, seen, w);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL en_complete: upd_2 not seen within 400 cycles after enable drop");
        end
        checks++;
        if (x_2 !== 10'h312 || y_2 !== 10'h056 || btn_2 !== 3'b010) begin
            errors++;
            $display("FAIL en_decode2: x=%h y=%h btn=%b want 312 056 010", x_2, y_2, btn_2);
        end
        viol = 0;
        repeat (2000) begin
            @(negedge clk);
            if (!ss_1 || !ss_2 || busy) viol++;
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL en_park: %0d active cycles while disabled want 0", viol);
        end
        enable = 1'b1;
        wait_sig(3, 5, seen, w);
        checks++;
        if (!seen || w != 1 || ss_2 !== 1'b1) begin
            errors++;
            $display("FAIL en_resume: dev1 seen=%0d after %0d ss_2=%b want 1 after 1 ss_2=1", seen, w, ss_2);
        end
        $display("txn dev2 (enable dropped): x=%h y=%h btn=%b park_viol=%0d", x_2, y_2, btn_2, viol);
    endtask

    task automatic test_reset_mid();
        bit seen;
        int w;
        int u1, u2;
        repeat (270) @(negedge clk);
        u1 = upd1_cnt;
        u2 = upd2_cnt;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({ss_1, ss_2, sclk, busy, upd_1, upd_2} !== 6'b110000) begin
            errors++;
            $display("FAIL rstmid_async: got %b want 110000", {ss_1, ss_2, sclk, busy, upd_1, upd_2});
        end
        checks++;
        if ({x_1, y_1, btn_1, x_2, y_2, btn_2} !== 46'd0) begin
            errors++;
            $display("FAIL rstmid_data: got %h want 0", {x_1, y_1, btn_1, x_2, y_2, btn_2});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_sig(3, 5, seen, w);
        checks++;
        if (!seen || w != 1 || ss_2 !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_restart: dev1 seen=%0d after %0d want 1 after 1", seen, w);
        end
        checks++;
        if (upd1_cnt != u1 || upd2_cnt != u2) begin
            errors++;
            $display("FAIL rstmid_no_upd: upd counts %0d/%0d want %0d/%0d", upd1_cnt, upd2_cnt, u1, u2);
        end
        wait_sig(1, 500, seen, w);
        checks++;
        if (!seen || x_1 !== 10'h234 || y_1 !== 10'h1CD || btn_1 !== 3'b101 || x_2 !== 10'h0) begin
            errors++;
            $display("FAIL rstmid_repoll: seen=%0d x1=%h y1=%h btn1=%b x2=%h want 1 234 1cd 101 000",
                     seen, x_1, y_1, btn_1, x_2);
        end
        $display("txn reset mid-byte3 then dev1: x=%h y=%h btn=%b", x_1, y_1, btn_1);
    endtask

    initial begin
        test_reset();
        test_first_txn();
        test_alternate();
        test_enable_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
